// File: rtl/btn_event.sv
// Turns one debounced button level into registered press/release/click/long/repeat pulses.
// Build option: define BTN_EVENT_REPEAT_EN to enable auto-repeat; otherwise repeat_p stays 0.
module btn_event #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_state,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

`ifdef BTN_EVENT_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [31:0] LONG_TC   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        btn_prev;
    logic [31:0] cnt, cnt_nxt;
    logic        press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt, held_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            btn_prev  <= 1'b0;
            cnt       <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            long_p    <= 1'b0;
            repeat_p  <= 1'b0;
            held      <= 1'b0;
        end else begin
            state     <= state_nxt;
            btn_prev  <= btn_state;
            cnt       <= cnt_nxt;
            press_p   <= press_nxt;
            release_p <= release_nxt;
            click_p   <= click_nxt;
            long_p    <= long_nxt;
            repeat_p  <= repeat_nxt;
            held      <= held_nxt;
        end
    end

    // Release is checked before the terminal count so it always wins a tie.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_state && !btn_prev) begin
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!btn_state) begin
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end else if (cnt == LONG_TC) begin
                    long_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = LONG;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            LONG: begin
                if (!btn_state) begin
                    release_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (!REPEAT_EN) begin
                    cnt_nxt = '0;
                end else if (cnt == REPEAT_TC) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        held_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_btn_event;

`ifdef BTN_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    // Output vector bit order: press, release, click, long, repeat, held
    localparam logic [5:0] B_PRESS = 6'b100000;
    localparam logic [5:0] B_REL   = 6'b010000;
    localparam logic [5:0] B_CLICK = 6'b001000;
    localparam logic [5:0] B_LONG  = 6'b000100;
    localparam logic [5:0] B_REP   = 6'b000010;
    localparam logic [5:0] B_HELD  = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_state = 1'b0;
    logic press_p, release_p, click_p, long_p, repeat_p, held;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    btn_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_state (btn_state),
        .press_p   (press_p),
        .release_p (release_p),
        .click_p   (click_p),
        .long_p    (long_p),
        .repeat_p  (repeat_p),
        .held      (held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {press_p, release_p, click_p, long_p, repeat_p, held};
    endfunction

    task automatic check_now(input string name, input logic [5:0] want);
        tests++;
        if (outs() !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, outs(), want);
        end
    endtask

    task automatic push(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Expected window for a hold of len cycles starting in cycle p (offsets hand-derived per test).
    task automatic expect_hold(input int p, input int len, input bit click,
                               input int long_at, input int r1, input int r2);
        for (int k = 0; k <= len + 2; k++) begin
            logic [5:0] v;
            v = '0;
            if (k == 0) v |= B_PRESS;
            if (k < len) v |= B_HELD;
            if (k == len) v |= B_REL | (click ? B_CLICK : 6'b0);
            if (k == long_at) v |= B_LONG;
            if (REP_EN && (k == r1 || k == r2)) v |= B_REP;
            push(p + k, v);
        end
    endtask

    task automatic run_hold(input int len, input bit click,
                            input int long_at, input int r1, input int r2);
        @(negedge clk);
        expect_hold(cyc + 1, len, click, long_at, r1, r2);
        btn_state = 1'b1;
        repeat (len) @(negedge clk);
        btn_state = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: compares every cycle the scoreboard has an entry for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_entry cyc=%0d got=none want=%b", e.cyc, e.vec);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                tests++;
                if (outs() !== e.vec) begin
                    fails++;
                    $display("FAIL sb_cycle cyc=%0d got=%b want=%b", cyc, outs(), e.vec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(negedge clk);
        check_now("reset_state", 6'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_now("idle_after_reset", 6'b0);

        run_hold(3, 1'b1, -1, -1, -1);    // short press
        run_hold(20, 1'b0, 8, 12, 16);    // long hold with repeats
        run_hold(8, 1'b1, -1, -1, -1);    // release on the terminal-count cycle
        run_hold(9, 1'b0, 8, -1, -1);     // release one cycle after long_p
        run_hold(13, 1'b0, 8, 12, -1);    // release one cycle after first repeat

        // Back-to-back: press, release, press on consecutive cycles
        @(negedge clk);
        p = cyc + 1;
        push(p,     B_PRESS | B_HELD);
        push(p + 1, B_REL | B_CLICK);
        push(p + 2, B_PRESS | B_HELD);
        push(p + 3, B_HELD);
        push(p + 4, B_HELD);
        push(p + 5, B_REL | B_CLICK);
        push(p + 6, 6'b0);
        btn_state = 1'b1;
        @(negedge clk) btn_state = 1'b0;
        @(negedge clk) btn_state = 1'b1;
        repeat (3) @(negedge clk);
        btn_state = 1'b0;
        repeat (5) @(negedge clk);

        // Reset mid-hold, then release reset with the button still pressed
        p = cyc + 1;
        for (int k = 0; k < 5; k++) push(p + k, (k == 0) ? (B_PRESS | B_HELD) : B_HELD);
        btn_state = 1'b1;
        while (cyc < p + 5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_now("async_reset_clears", 6'b0);
        repeat (2) @(negedge clk);
        check_now("held_in_reset", 6'b0);
        expect_hold(cyc + 1, 14, 1'b0, 8, 12, -1);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        btn_state = 1'b0;
        repeat (5) @(negedge clk);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drained got=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
